imem_prog_arbiter: RTL
======================

# imem_prog_arbiter

Controller that shares the single-port instruction memory (`text_32_14`) between the instruction fetch path and the UART programmer. It sequences the memory between a RUN phase (fetch reads) and a PROG phase (programmer writes), and drains the fetch path before switching. It holds the CPU in reset while programming and for a fixed release window afterwards. It sits between the fetch unit, the UART programmer and the memory's port A; all programmer signals arrive already synchronised to `clk_i`.

## Interface
Parameters:
- `ADDR_W`, 14, memory word-address width
- `DATA_W`, 32, memory word width
- `RELEASE_CYC`, 2, cycles `cpu_reset_o` is held after programming ends (≥1)

Ports (one clock; reset is asynchronous, active-low):
- `clk_i`  in  1  system clock; all state updates on rising edge
- `reset_n_i`  in  1  asynchronous active-low reset
- `fetch_addr_i`  in  ADDR_W  fetch word address (pc[13:0])
- `fetch_stall_o`  out  1  fetch must hold pc; high in every state except RUN
- `prog_start_i`  in  1  single-cycle pulse that requests the PROG phase
- `prog_wen_i`  in  1  write strobe, one word per cycle max
- `prog_addr_i`  in  ADDR_W  write address
- `prog_data_i`  in  DATA_W  write data
- `prog_done_i`  in  1  single-cycle pulse that ends the PROG phase
- `prog_ack_o`  out  1  pulses the cycle an accepted word is written
- `mem_we_o`  out  1  memory write enable
- `mem_addr_o`  out  ADDR_W  memory address
- `mem_wdata_o`  out  DATA_W  memory write data
- `cpu_reset_o`  out  1  active-high reset to the fetch/PC logic
- `mode_o`  out  2  current state encoding
- `word_cnt_o`  out  ADDR_W+1  words written in the current or last PROG phase
- `err_o`  out  1  sticky; a write was attempted outside PROG

## Operation
- States and encodings: RUN=0, DRAIN=1, PROG=2, RELEASE=3. Reset state is RUN.
- RUN
  - Memory is read-only for fetch: `mem_addr_o`=`fetch_addr_i` (combinational), `mem_we_o`=0.
  - `prog_start_i` → DRAIN.
- DRAIN
  - One cycle. The stall is already asserted and the in-flight read completes.
  - Then unconditionally → PROG, clearing `word_cnt_o` to 0.
- PROG
  - `cpu_reset_o`=1.
  - `prog_wen_i` is captured into a one-entry write register (addr, data).
  - The next cycle drives `mem_we_o`=1, `mem_addr_o`/`mem_wdata_o` from that register, and pulses `prog_ack_o`.
  - `word_cnt_o`+1, saturating at 2^ADDR_W.
  - Duplicate addresses are written again and counted again.
- `prog_done_i` in PROG → RELEASE.
  - If `prog_wen_i` is high in the same cycle, that word is still captured; its write occurs in the first RELEASE cycle.
- RELEASE
  - `cpu_reset_o`=1 for exactly RELEASE_CYC cycles (down-counter), then → RUN.
  - Addresses are muxed from the write register only while a write is pending, else from `fetch_addr_i`.
- Ignored inputs:
  - `prog_start_i` outside RUN.
  - `prog_done_i` outside PROG.
- `prog_wen_i` in RUN, DRAIN or RELEASE: dropped, no memory write, `err_o` set. `err_o` clears only on reset.
- `word_cnt_o` holds its value outside PROG until the next DRAIN→PROG.

## Timing
- Reset values (async, immediate):
  - state RUN, `mem_we_o`=0, `prog_ack_o`=0, `cpu_reset_o`=0.
  - `word_cnt_o`=0, `err_o`=0, write register=0, release counter=0.
  - `fetch_stall_o`=0.
- Write latency: `prog_wen_i` sampled at edge N → `mem_we_o`/`prog_ack_o` high during cycle N+1, one cycle wide.
- Throughput: one word per cycle, back-to-back.
- Phase latencies:
  - `prog_start_i` at edge N → `fetch_stall_o` high from N+1.
  - PROG entered at N+2; first write can be sampled at N+2.
  - RELEASE→RUN: `fetch_stall_o` and `cpu_reset_o` both drop in the same cycle.
- Reset mid-PROG: any pending write is discarded (not written). State returns to RUN.
- All outputs except `mem_addr_o` in RUN and `fetch_stall_o` are registered.

## Structure
- Shared package `imem_pkg`:
  - state typedef / localparams RUN/DRAIN/PROG/RELEASE.
  - `IMEM_ADDR_W`=14, `IMEM_DATA_W`=32.
- Single module; no sub-module required.
- The release counter is a `$clog2(RELEASE_CYC+1)`-bit down-counter inside the FSM.

## Test plan
- Reset then RUN with `fetch_addr_i`=0x0123 → `mem_addr_o`=0x0123, `mem_we_o`=0, `fetch_stall_o`=0, `mode_o`=0.
- `prog_start_i` pulse → `mode_o` 1 for one cycle, then 2; `cpu_reset_o`=1; `word_cnt_o`=0.
- Three back-to-back writes {0x0000:0xDEADBEEF, 0x0001:0x12345678, 0x3FFF:0x0000000F} → three consecutive `mem_we_o` pulses one cycle later with matching addr/data; `word_cnt_o`=3.
- `prog_wen_i` (0x0002:0xA5A5A5A5) in the same cycle as `prog_done_i` → the write occurs in the first RELEASE cycle; `cpu_reset_o` is high for exactly 2 cycles; then `mode_o`=0 and `fetch_stall_o`=0.
- `prog_wen_i` asserted in RUN → no `mem_we_o`, `err_o`=1 and stays 1; `prog_start_i` while in PROG → no state change.
- `reset_n_i` low while a write is captured → no `mem_we_o` pulse; all outputs take their reset values immediately.

Source files
------------

// File: rtl/imem_pkg.sv
// imem_pkg
// Shared definitions for the instruction-memory programming path:
// memory geometry and the arbiter phase encoding seen on mode_o.
package imem_pkg;

  localparam int IMEM_ADDR_W = 14;
  localparam int IMEM_DATA_W = 32;

  // Phase encoding; the numeric values are visible on mode_o.
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    PROG    = 2'd2,
    RELEASE = 2'd3
  } imem_state_e;

endpackage

// File: rtl/imem_prog_arbiter.sv
// imem_prog_arbiter
// Shares the single-port instruction memory between instruction fetch and
// the UART programmer. Fetch owns the memory in RUN; a programming request
// stalls fetch, lets the in-flight read finish (DRAIN), then hands the port
// to the programmer (PROG). After programming the CPU stays in reset for a
// fixed window (RELEASE) before fetch resumes.
//
// Ports:
//   clk_i, reset_n_i          clock, asynchronous active-low reset
//   fetch_addr_i              fetch word address
//   fetch_stall_o             fetch must hold pc (every phase but RUN)
//   prog_start_i/prog_done_i  programmer phase pulses
//   prog_wen_i/addr/data      programmer write strobe, address and data
//   prog_ack_o                pulses when an accepted word is written
//   mem_we_o/addr_o/wdata_o   memory port A
//   cpu_reset_o               reset to fetch/PC logic
//   mode_o                    current phase
//   word_cnt_o                words accepted in current/last PROG phase
//   err_o                     sticky: write attempted outside PROG
module imem_prog_arbiter
  import imem_pkg::*;
#(
  parameter int ADDR_W      = IMEM_ADDR_W,
  parameter int DATA_W      = IMEM_DATA_W,
  parameter int RELEASE_CYC = 2
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic [ADDR_W-1:0] fetch_addr_i,
  output logic              fetch_stall_o,
  input  logic              prog_start_i,
  input  logic              prog_wen_i,
  input  logic [ADDR_W-1:0] prog_addr_i,
  input  logic [DATA_W-1:0] prog_data_i,
  input  logic              prog_done_i,
  output logic              prog_ack_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              cpu_reset_o,
  output logic [1:0]        mode_o,
  output logic [ADDR_W:0]   word_cnt_o,
  output logic              err_o
);

  localparam int REL_W = $clog2(RELEASE_CYC + 1);
  localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  imem_state_e       state_q, state_d;
  logic [REL_W-1:0]  rel_cnt_q, rel_cnt_d;
  logic              cpu_reset_q;
  logic              wr_pend_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic [ADDR_W:0]   word_cnt_q;
  logic              err_q;
  logic              capture;

  // Writes are only accepted while the programmer owns the memory; a word
  // arriving together with prog_done_i is still taken.
  assign capture = prog_wen_i && (state_q == PROG);

  // Next-phase logic. RELEASE counts down from RELEASE_CYC so the CPU reset
  // window is exactly RELEASE_CYC cycles long.
  always_comb begin
    state_d   = state_q;
    rel_cnt_d = rel_cnt_q;
    unique case (state_q)
      RUN:   if (prog_start_i) state_d = DRAIN;
      DRAIN: state_d = PROG;
      PROG: begin
        if (prog_done_i) begin
          state_d   = RELEASE;
          rel_cnt_d = REL_W'(RELEASE_CYC);
        end
      end
      RELEASE: begin
        if (rel_cnt_q <= REL_W'(1)) begin
          state_d   = RUN;
          rel_cnt_d = '0;
        end else begin
          rel_cnt_d = rel_cnt_q - REL_W'(1);
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Phase register. cpu_reset is registered from the next phase so that it
  // falls in the same cycle fetch_stall_o does on RELEASE -> RUN.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= RUN;
      rel_cnt_q   <= '0;
      cpu_reset_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rel_cnt_q   <= rel_cnt_d;
      cpu_reset_q <= (state_d == PROG) || (state_d == RELEASE);
    end
  end

  // One-entry write register; the pending flag is the write pulse itself.
  // Reset drops any pending word so it is never written.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_pend_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_pend_q <= capture;
      if (capture) begin
        wr_addr_q <= prog_addr_i;
        wr_data_q <= prog_data_i;
      end
    end
  end

  // Word counter cleared on DRAIN -> PROG, saturating at 2^ADDR_W; the
  // sticky error flags writes attempted while the programmer lacks the port.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      word_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (state_q == DRAIN) begin
        word_cnt_q <= '0;
      end else if (capture && (word_cnt_q != CNT_MAX)) begin
        word_cnt_q <= word_cnt_q + 1'b1;
      end
      if (prog_wen_i && (state_q != PROG)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign fetch_stall_o = (state_q != RUN);
  assign mode_o        = state_q;
  assign cpu_reset_o   = cpu_reset_q;
  assign mem_we_o      = wr_pend_q;
  assign prog_ack_o    = wr_pend_q;
  assign mem_addr_o    = wr_pend_q ? wr_addr_q : fetch_addr_i;
  assign mem_wdata_o   = wr_data_q;
  assign word_cnt_o    = word_cnt_q;
  assign err_o         = err_q;

endmodule
